ex_div: RTL
===========

// Module: ex_div
// PURPOSE
//  Iterative radix-2 restoring divider for the EX stage. It consumes the operand pair the
//  ID/EX register delivers (ex_reg1 = dividend, ex_reg2 = divisor) for DIV/DIVU.
//  It returns {remainder, quotient} for the HI/LO write path. EX stalls the pipeline
//  while start_i is high and ready_o is low.
// PARAMETERS
//  DATA_W   32   operand width; result is 2*DATA_W; iteration count = DATA_W
// PORTS
//  clk           in   1         pipeline clock; all state updates on posedge
//  rst           in   1         synchronous, active-high reset (rst == `RstEnable)
//  signed_div_i  in   1         1 = DIV (two's complement), 0 = DIVU
//  opdata1_i     in   DATA_W    dividend; sampled only on accept
//  opdata2_i     in   DATA_W    divisor; sampled only on accept
//  start_i       in   1         request; held high by EX until ready_o seen
//  annul_i       in   1         abort (branch/exception flush); priority over start_i
//  result_o      out  2*DATA_W  {remainder, quotient}; HI = [63:32], LO = [31:0]
//  ready_o       out  1         result_o valid; high only in END state
// BEHAVIOUR
//  Reset: state = FREE, cnt = 0, result_o = 0, ready_o = `DivResultNotReady.
//  FREE: if start_i && !annul_i, the block accepts the request and latches operands.
//   - Divisor == 0: go to BYZERO.
//   - Otherwise: go to ON with cnt = 0 and dividend reg = {DATA_W'b0, |op1|, 1'b0}
//     (2*DATA_W+1 bits).
//   - Magnitudes |op| are taken only when signed_div_i = 1 and op[MSB] = 1; else raw op.
//  BYZERO: the next edge goes to END with result_o = 0 (no trap raised).
//  ON: each edge, diff = dividend[2W:W] - {1'b0, |op2|}.
//   - diff[W] = 1 (negative): dividend <<= 1.
//   - Else: dividend = {diff[W-1:0], dividend[W-1:0], 1'b1}.
//   - cnt increments each edge. When cnt == W, go to END.
//   - Sign fix-up on the way to END (signed_div_i = 1 only):
//     quotient is negated if sign1 ^ sign2; remainder is negated if sign1.
//   - result_o is registered on the transition into END.
//  END: ready_o = 1, result_o held stable. If !start_i, go to FREE next edge, clearing
//   ready_o and result_o.
//  annul_i = 1 in any state: go to FREE next edge with ready_o = 0; the partial result
//   is discarded.
//  Latency, with the accept edge = E0:
//   - Normal: ready_o high after edge E(W+1) (33 for W = 32).
//   - Divide by zero: ready_o high after E2.
//  Boundaries:
//   - Start is ignored in ON/BYZERO/END. Operands are not re-sampled mid-operation.
//   - -2^31 / -1 (signed): q = 0x80000000, r = 0 (wraps, no flag).
//   - rst mid-operation: return to FREE exactly as at reset, regardless of annul_i/start_i.
//   - start_i and annul_i together in FREE: nothing is accepted.
// CONFIGURATION
//  DIV_SIGNED_EN defined: signed_div_i is honoured as above.
//  DIV_SIGNED_EN undefined:
//   - signed_div_i is ignored and all operations are unsigned (DIVU semantics).
//   - No magnitude/negation logic is built; latency is unchanged.
// STRUCTURE
//  Shared defines.v gains:
//   - state encodings: `DivFree, `DivByZero, `DivOn, `DivEnd (2-bit)
//   - ready/control levels: `DivResultReady / `DivResultNotReady, `DivStart / `DivStop
//  Existing constants reused: `RstEnable, `ZeroWord, `RegBus, `DoubleRegBus.
//  Sub-module: none. Single FSM plus datapath in one module; the trial subtract stays inline.
// TESTING
//  1 DIVU 100 / 7 -> ready_o after E33; result_o = 0x00000002_0000000E.
//  2 DIV -7 / 2 -> result_o = 0xFFFFFFFF_FFFFFFFD (r = -1, q = -3). With DIV_SIGNED_EN
//    undefined: 0x00000001_7FFFFFFC.
//  3 DIVU 5 / 0 -> ready_o after E2; result_o = 0. With start_i held, stays in END;
//    start_i low -> FREE, ready_o = 0.
//  4 DIVU 0xFFFFFFFF / 1 -> 0x00000000_FFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF
//    -> 0x00000000_80000000.
//  5 annul_i pulse at E10 of a 100/7 divide -> FREE after E11, ready_o never rises.
//    Next start 9/3 -> 0x00000000_00000003 after its own E33.
//  6 rst asserted at E20 of an operation -> all outputs 0 after that edge; a new start
//    afterwards completes normally.

Source files
------------

// File: rtl/ex_div_pkg.sv
// Shared constants for the EX-stage divider: FSM encodings, handshake levels, default width.
package ex_div_pkg;

  localparam int unsigned DIV_DATA_W = 32;

  localparam logic [1:0] DIV_FREE   = 2'b00;
  localparam logic [1:0] DIV_BYZERO = 2'b01;
  localparam logic [1:0] DIV_ON     = 2'b10;
  localparam logic [1:0] DIV_END    = 2'b11;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/ex_div_if.sv
// EX <-> divider request/response bundle; master = EX stage, slave = divider.
interface ex_div_if
  import ex_div_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W
);

  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for the EX stage; result_o = {remainder, quotient}.
// Define DIV_SIGNED_EN to honour signed_div_i (DIV); otherwise every request is DIVU.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W
) (
  input  logic    clk,
  input  logic    rst,
  ex_div_if.slave div_if
);

  localparam int unsigned       CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W:0]     dividend_q, dividend_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  logic                  accept_s;
  logic [DATA_W:0]       diff_s;
  logic [DATA_W-1:0]     op1_mag_s, op2_mag_s;
  logic [DATA_W-1:0]     quot_raw_s, rem_raw_s, quot_fix_s, rem_fix_s;

  assign accept_s   = (state_q == DIV_FREE) && (div_if.start_i == DIV_START) && !div_if.annul_i;
  assign diff_s     = dividend_q[2*DATA_W:DATA_W] - {1'b0, divisor_q};
  assign quot_raw_s = dividend_q[DATA_W-1:0];
  assign rem_raw_s  = dividend_q[2*DATA_W:DATA_W+1];

`ifdef DIV_SIGNED_EN
  logic neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d;
  logic sign1_s, sign2_s;

  function automatic logic [DATA_W-1:0] cond_negate(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

  assign sign1_s    = div_if.signed_div_i & div_if.opdata1_i[DATA_W-1];
  assign sign2_s    = div_if.signed_div_i & div_if.opdata2_i[DATA_W-1];
  assign op1_mag_s  = cond_negate(div_if.opdata1_i, sign1_s);
  assign op2_mag_s  = cond_negate(div_if.opdata2_i, sign2_s);
  assign quot_fix_s = cond_negate(quot_raw_s, neg_quot_q);
  assign rem_fix_s  = cond_negate(rem_raw_s, neg_rem_q);

  // Operand signs are captured with the operands so a later flip of signed_div_i is harmless.
  always_comb begin
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    if (accept_s) begin
      neg_quot_d = sign1_s ^ sign2_s;
      neg_rem_d  = sign1_s;
    end else begin
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
    end
  end

  // Sign-flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end
`else
  assign op1_mag_s  = div_if.opdata1_i;
  assign op2_mag_s  = div_if.opdata2_i;
  assign quot_fix_s = quot_raw_s;
  assign rem_fix_s  = rem_raw_s;
`endif

  // FSM next state and restoring-division datapath; annul_i overrides every state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    result_d   = result_q;
    ready_d    = ready_q;
    if (div_if.annul_i) begin
      state_d  = DIV_FREE;
      cnt_d    = '0;
      result_d = '0;
      ready_d  = DIV_RESULT_NOT_READY;
    end else begin
      case (state_q)
        DIV_FREE: begin
          if (accept_s) begin
            cnt_d = '0;
            if (div_if.opdata2_i == '0) begin
              state_d = DIV_BYZERO;
            end else begin
              state_d    = DIV_ON;
              dividend_d = {{DATA_W{1'b0}}, op1_mag_s, 1'b0};
              divisor_d  = op2_mag_s;
            end
          end else begin
            state_d = DIV_FREE;
          end
        end
        // Divide-by-zero dwells one extra edge so ready_o rises two edges after accept.
        DIV_BYZERO: begin
          if (cnt_q == '0) begin
            cnt_d = CNT_ONE;
          end else begin
            state_d  = DIV_END;
            cnt_d    = '0;
            result_d = '0;
            ready_d  = DIV_RESULT_READY;
          end
        end
        DIV_ON: begin
          if (cnt_q == CNT_LAST) begin
            state_d  = DIV_END;
            cnt_d    = '0;
            result_d = {rem_fix_s, quot_fix_s};
            ready_d  = DIV_RESULT_READY;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (diff_s[DATA_W]) begin
              dividend_d = {dividend_q[2*DATA_W-1:0], 1'b0};
            end else begin
              dividend_d = {diff_s[DATA_W-1:0], dividend_q[DATA_W-1:0], 1'b1};
            end
          end
        end
        DIV_END: begin
          if (div_if.start_i == DIV_STOP) begin
            state_d  = DIV_FREE;
            result_d = '0;
            ready_d  = DIV_RESULT_NOT_READY;
          end else begin
            state_d = DIV_END;
          end
        end
        default: begin
          state_d  = DIV_FREE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end
      endcase
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
      ready_q    <= DIV_RESULT_NOT_READY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign div_if.result_o = result_q;
  assign div_if.ready_o  = ready_q;

endmodule
